clk_period_meter: RTL and testbench
===================================

Name: clk_period_meter

Overview:
- Receiving end of the clock-divider interface: measures a divided square wave and recovers the divide value N that produced it.
- A divider with setting N toggles its output every N+1 source cycles. This block counts source cycles between consecutive transitions and reports N = distance − 1.
- Used for self-check of divider outputs and for measuring external slow clocks. It also flags lock (stable N) and loss of signal.

Parameters:
- MAX_N, 1000000: largest reportable N. No transition within MAX_N+1 cycles of the previous one is a timeout.
- LOCK_CNT, 4: number of consecutive identical measurements, after the first, required before O_LOCK asserts. Must be ≥1.

Ports:
- I_CLK  input  1  measurement clock; the divider's source clock.
- I_RST  input  1  synchronous reset, active-high.
- I_SIG  input  1  square wave under measurement; may be asynchronous to I_CLK.
- O_N  output  32  last measured N. Held between measurements.
- O_VALID  output  1  one-cycle pulse when O_N is updated.
- O_LOCK  output  1  high while the last LOCK_CNT+1 measurements were identical.
- O_TIMEOUT  output  1  one-cycle pulse on loss of signal.

Behaviour:
- Reset: I_RST is sampled on the rising edge of I_CLK. When high, the following are cleared to 0 on that edge:
  - O_N, O_VALID, O_LOCK, O_TIMEOUT
  - cycle counter and match counter
  - both synchronizer flops and the edge-history flop
  - state is set to IDLE
- Reset mid-measurement discards the partial count. No O_VALID or O_TIMEOUT is produced for it.
- Input path: I_SIG → 2-flop synchronizer → history flop.
  - An edge is detected when synchronizer output ≠ history flop. Both rising and falling transitions count.
  - The first sample after reset is not an edge; the history flop loads the synchronized value.
- Fixed latency: O_VALID or O_TIMEOUT is registered, asserting 3 I_CLK cycles after the cycle in which the I_SIG transition is first sampled. Fixed latency preserves the distance D between edges.
- Cycle counter: 32-bit.
  - On an edge cycle it is cleared to 0.
  - On every non-edge cycle it increments.
  - At the next edge it holds D−1, which is loaded into O_N. D=1 gives O_N=0.
- States:
  - IDLE: no reference edge yet. The counter is held at 0. The first edge moves to MEASURE; no O_VALID.
  - MEASURE: counting. On an edge, O_N ← count and O_VALID pulses; stay in MEASURE, or go to LOCKED when the match counter reaches LOCK_CNT.
  - LOCKED: same as MEASURE with O_LOCK=1. A measurement ≠ previous O_N clears O_LOCK in the same cycle as its O_VALID and returns to MEASURE.
- Match counter:
  - First measurement after IDLE: set to 0.
  - New value == previous O_N: increment, saturating at LOCK_CNT.
  - New value ≠ previous O_N: clear to 0.
  - O_LOCK = (match counter == LOCK_CNT) and state is LOCKED.
- Timeout applies in MEASURE or LOCKED:
  - Condition: a non-edge cycle with count == MAX_N.
  - Result: O_TIMEOUT pulses, O_N and O_LOCK clear to 0, the match counter clears, and the state goes to IDLE.
  - An edge arriving exactly when count == MAX_N is a valid measurement (O_N = MAX_N), not a timeout.
  - No timeout is generated in IDLE; a static input after reset stays silent.
- Simultaneous events: reset has priority over edge and timeout.
- The counter never wraps, because timeout fires at MAX_N < 2^32−1.

Test Plan:
- Reset, then I_SIG driven by a divider model with N=3 (toggle every 4 cycles). Required response:
  - First O_VALID on the 2nd transition with O_N=3.
  - O_LOCK rises on the 5th O_VALID (LOCK_CNT=4).
  - O_TIMEOUT stays 0 throughout.
- Divider N=0 (I_SIG toggles every cycle) → O_VALID every cycle with O_N=0, and O_LOCK after 5 measurements.
- Locked at N=3, switch the divider to N=7. Required response:
  - First new O_VALID carries O_N=7 with O_LOCK=0 in that same cycle.
  - O_LOCK reasserts after 4 further measurements of 7.
- MAX_N=15, lock at N=5, then hold I_SIG static. Required response:
  - O_TIMEOUT pulses once, 16 cycles after the last edge cycle.
  - O_N=0 and O_LOCK=0; no further pulses.
  - The next two transitions give one O_VALID, on the second transition only.
- MAX_N=15, edges exactly 16 cycles apart → O_VALID with O_N=15 and no O_TIMEOUT. Edges 17 cycles apart → O_TIMEOUT only.
- Assert I_RST for one cycle mid-count at N=9 while locked. Required response:
  - All outputs are 0 the cycle after reset.
  - No pulse is generated for the interrupted period.
  - Relock at O_N=9 is required to follow the normal IDLE sequence.

Source files
------------

// File: rtl/clk_period_meter.sv
// clk_period_meter: recovers the divide value N of a divided square wave by counting source cycles between its transitions
//   I_CLK      in   1  measurement clock, the divider's source clock
//   I_RST      in   1  synchronous active-high reset
//   I_SIG      in   1  square wave under measurement, may be asynchronous to I_CLK
//   O_N        out 32  last measured N (edge distance - 1), held between measurements
//   O_VALID    out  1  one-cycle pulse when O_N is updated
//   O_LOCK     out  1  high while the last LOCK_CNT+1 measurements were identical
//   O_TIMEOUT  out  1  one-cycle pulse on loss of signal
module clk_period_meter #(
   parameter int unsigned MAX_N    = 1000000,
   parameter int unsigned LOCK_CNT = 4
) (
   input  logic        I_CLK,
   input  logic        I_RST,
   input  logic        I_SIG,
   output logic [31:0] O_N,
   output logic        O_VALID,
   output logic        O_LOCK,
   output logic        O_TIMEOUT
);
   localparam int unsigned    MW     = $clog2(LOCK_CNT + 1);
   localparam logic [31:0]    MAX_C  = 32'(MAX_N);
   localparam logic [MW-1:0]  LOCK_M = MW'(LOCK_CNT);
   typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
   state_t        state;
   logic          sync1, sync2, hist, first;
   logic [2:0]    warm;
   logic [31:0]   count;
   logic [MW-1:0] match, match_nx;
   logic          edge_det, timeout;
   // warm masks edges until the history flop holds a genuinely synchronized sample,
   // so a static-high input at reset release is not mistaken for a transition
   always_comb begin
      edge_det = warm[2] && (sync2 != hist);
      timeout  = (state != IDLE) && !edge_det && (count == MAX_C);
      match_nx = (first || count != O_N) ? '0 : (match == LOCK_M) ? match : match + MW'(1);
   end
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         hist      <= 1'b0;
         warm      <= '0;
         first     <= 1'b0;
         count     <= '0;
         match     <= '0;
         state     <= IDLE;
         O_N       <= '0;
         O_VALID   <= 1'b0;
         O_LOCK    <= 1'b0;
         O_TIMEOUT <= 1'b0;
      end else begin
         sync1     <= I_SIG;
         sync2     <= sync1;
         hist      <= sync2;
         warm      <= {warm[1:0], 1'b1};
         O_VALID   <= 1'b0;
         O_TIMEOUT <= 1'b0;
         if (state == IDLE) begin
            count <= '0;
            if (edge_det) begin
               state <= MEASURE;
               first <= 1'b1;
            end
         end else if (edge_det) begin
            // count holds distance-1 here; first marks a measurement with no predecessor to match
            count   <= '0;
            O_N     <= count;
            O_VALID <= 1'b1;
            first   <= 1'b0;
            match   <= match_nx;
            O_LOCK  <= (match_nx == LOCK_M);
            state   <= (match_nx == LOCK_M) ? LOCKED : MEASURE;
         end else if (timeout) begin
            count     <= '0;
            match     <= '0;
            O_N       <= '0;
            O_LOCK    <= 1'b0;
            O_TIMEOUT <= 1'b1;
            state     <= IDLE;
         end else begin
            count <= count + 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: randomized self-checking bench comparing output events against an edge-gap reference model
module tb_clk_period_meter;
   localparam int MAXN = 15;
   localparam int LCNT = 4;
   localparam int LAT  = 3;
   typedef struct packed {
      logic [31:0] cyc;
      logic        to;
      logic [31:0] n;
      logic        lk;
   } ev_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sig = 1'b0;
   logic [31:0] o_n;
   logic        o_valid, o_lock, o_timeout;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   ev_t         obs_q[$];
   ev_t         exp_q[$];
   int          meas[$];
   bit          have_ref = 0;
   int          last = 0;
   ev_t         o, e;
   clk_period_meter #(.MAX_N(MAXN), .LOCK_CNT(LCNT)) dut (
      .I_CLK(clk), .I_RST(rst), .I_SIG(sig),
      .O_N(o_n), .O_VALID(o_valid), .O_LOCK(o_lock), .O_TIMEOUT(o_timeout)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (o_valid || o_timeout) begin
         ev_t m;
         m.cyc = 32'(cyc);
         m.to  = o_timeout;
         m.n   = o_n;
         m.lk  = o_lock;
         obs_q.push_back(m);
      end
   end
   function automatic void push_ev(int c, bit t, int n, bit l);
      ev_t x;
      x.cyc = 32'(c);
      x.to  = t;
      x.n   = 32'(n);
      x.lk  = l;
      exp_q.push_back(x);
   endfunction
   function automatic void model_reset();
      have_ref = 0;
      meas.delete();
   endfunction
   // a gap longer than MAXN+1 means the signal was lost; the timeout surfaces MAXN+1 cycles after the last edge
   function automatic void model_flush(int now);
      if (have_ref && now > last + MAXN + 1 + LAT) begin
         push_ev(last + MAXN + 1 + LAT, 1'b1, 0, 1'b0);
         model_reset();
      end
   endfunction
   function automatic void model_edge(int c);
      bit lk;
      if (have_ref && c - last > MAXN + 1) begin
         push_ev(last + MAXN + 1 + LAT, 1'b1, 0, 1'b0);
         model_reset();
      end
      if (have_ref) begin
         meas.push_back(c - last - 1);
         lk = meas.size() >= LCNT + 1;
         for (int i = 1; i <= LCNT && lk; i++)
            if (meas[meas.size() - 1 - i] != c - last - 1) lk = 0;
         push_ev(c + LAT, 1'b0, c - last - 1, lk);
      end
      have_ref = 1;
      last = c;
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic toggle();
      sig = ~sig;
      model_edge(cyc);
   endtask
   task automatic run_div(int n, int count);
      repeat (count) begin
         repeat (n + 1) tick();
         toggle();
      end
   endtask
   task automatic test_reset();
      repeat (3) tick();
      checks += 4;
      if (o_n !== 32'd0) begin errors++; $display("FAIL reset O_N got %0d want 0", o_n); end
      if (o_valid !== 1'b0) begin errors++; $display("FAIL reset O_VALID got %b want 0", o_valid); end
      if (o_lock !== 1'b0) begin errors++; $display("FAIL reset O_LOCK got %b want 0", o_lock); end
      if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset O_TIMEOUT got %b want 0", o_timeout); end
      rst = 1'b0;
      model_reset();
      obs_q.delete();
      repeat (30) tick();
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL reset_silent events got %0d want 0", obs_q.size()); end
      obs_q.delete();
   endtask
   task automatic test_div3();
      run_div(3, $urandom_range(8, 12));
      repeat (LAT + 2) tick();
      model_flush(cyc);
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL div3 count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL div3 event got cyc=%0d to=%b n=%0d lk=%b want cyc=%0d to=%b n=%0d lk=%b", o.cyc, o.to, o.n, o.lk, e.cyc, e.to, e.n, e.lk); end
      end
      obs_q.delete(); exp_q.delete();
      checks++;
      if (o_lock !== 1'b1) begin errors++; $display("FAIL div3_lock got %b want 1", o_lock); end
   endtask
   task automatic test_switch7();
      run_div(7, $urandom_range(6, 9));
      repeat (LAT + 2) tick();
      model_flush(cyc);
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL switch7 count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL switch7 event got cyc=%0d to=%b n=%0d lk=%b want cyc=%0d to=%b n=%0d lk=%b", o.cyc, o.to, o.n, o.lk, e.cyc, e.to, e.n, e.lk); end
      end
      obs_q.delete(); exp_q.delete();
   endtask
   task automatic test_div0();
      run_div(0, $urandom_range(8, 14));
      repeat (LAT + 2) tick();
      model_flush(cyc);
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL div0 count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL div0 event got cyc=%0d to=%b n=%0d lk=%b want cyc=%0d to=%b n=%0d lk=%b", o.cyc, o.to, o.n, o.lk, e.cyc, e.to, e.n, e.lk); end
      end
      obs_q.delete(); exp_q.delete();
   endtask
   task automatic test_timeout();
      run_div(5, 8);
      repeat (40) tick();
      model_flush(cyc);
      checks += 2;
      if (o_n !== 32'd0) begin errors++; $display("FAIL timeout_n got %0d want 0", o_n); end
      if (o_lock !== 1'b0) begin errors++; $display("FAIL timeout_lock got %b want 0", o_lock); end
      run_div(5, 2);
      repeat (LAT + 2) tick();
      model_flush(cyc);
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL timeout event got cyc=%0d to=%b n=%0d lk=%b want cyc=%0d to=%b n=%0d lk=%b", o.cyc, o.to, o.n, o.lk, e.cyc, e.to, e.n, e.lk); end
      end
      obs_q.delete(); exp_q.delete();
   endtask
   task automatic test_boundary();
      run_div(MAXN, 2);
      run_div(MAXN + 1, 1);
      run_div(MAXN, 2);
      repeat (LAT + 2) tick();
      model_flush(cyc);
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL boundary count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL boundary event got cyc=%0d to=%b n=%0d lk=%b want cyc=%0d to=%b n=%0d lk=%b", o.cyc, o.to, o.n, o.lk, e.cyc, e.to, e.n, e.lk); end
      end
      obs_q.delete(); exp_q.delete();
   endtask
   task automatic test_reset_mid();
      run_div(9, 8);
      repeat (5) tick();
      checks++;
      if (o_lock !== 1'b1) begin errors++; $display("FAIL rmid_prelock got %b want 1", o_lock); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      checks += 4;
      if (o_n !== 32'd0) begin errors++; $display("FAIL rmid O_N got %0d want 0", o_n); end
      if (o_valid !== 1'b0) begin errors++; $display("FAIL rmid O_VALID got %b want 0", o_valid); end
      if (o_lock !== 1'b0) begin errors++; $display("FAIL rmid O_LOCK got %b want 0", o_lock); end
      if (o_timeout !== 1'b0) begin errors++; $display("FAIL rmid O_TIMEOUT got %b want 0", o_timeout); end
      run_div(9, 7);
      repeat (LAT + 2) tick();
      model_flush(cyc);
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rmid count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL rmid event got cyc=%0d to=%b n=%0d lk=%b want cyc=%0d to=%b n=%0d lk=%b", o.cyc, o.to, o.n, o.lk, e.cyc, e.to, e.n, e.lk); end
      end
      obs_q.delete(); exp_q.delete();
   endtask
   task automatic test_random();
      repeat (6) begin
         run_div($urandom_range(0, 14), $urandom_range(3, 8));
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 24)) tick();
            toggle();
         end
      end
      repeat (25) tick();
      model_flush(cyc);
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL random event got cyc=%0d to=%b n=%0d lk=%b want cyc=%0d to=%b n=%0d lk=%b", o.cyc, o.to, o.n, o.lk, e.cyc, e.to, e.n, e.lk); end
      end
      obs_q.delete(); exp_q.delete();
   endtask
   initial begin
      test_reset();
      test_div3();
      test_switch7();
      test_div0();
      test_timeout();
      test_boundary();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
